// File: rtl/axis_frame_len_limit_if.sv
// AXI-Stream bundle used between the FIFO, the frame length limiter and its consumer.
interface axis_frame_len_limit_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned KEEP_WIDTH = 1,
  parameter int unsigned USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tready;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_len_limit.sv
// AXI-Stream frame length limiter: truncates frames longer than max_len and emits per-frame status.
// Optional frame_len/frame_len_valid reporting is enabled with AXIS_FRAME_LEN_STATUS_EN.
module axis_frame_len_limit #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH  = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = USER_WIDTH'(1'b1),
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  axis_frame_len_limit_if.slave         s_axis,
  axis_frame_len_limit_if.master        m_axis,
  input  logic [LEN_WIDTH-1:0]          max_len,
  output logic [LEN_WIDTH-1:0]          frame_len,
  output logic                          frame_len_valid,
  output logic                          status_good_frame,
  output logic                          status_truncated
);

  typedef enum logic [0:0] {ST_PASS = 1'b0, ST_DROP = 1'b1} state_e;

  state_e                state_q, state_d;
  logic                  in_frame_q, in_frame_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  lim_q, lim_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic                  tlast_q, tlast_d;
  logic [USER_WIDTH-1:0] tuser_q, tuser_d;
  logic                  tvalid_q, tvalid_d;
  logic                  good_q, good_d;
  logic                  trunc_q, trunc_d;

  logic [LEN_WIDTH-1:0]  beat_bytes;
  logic [LEN_WIDTH:0]    len_sum;
  logic [LEN_WIDTH-1:0]  new_len;
  logic [LEN_WIDTH-1:0]  lim;
  logic                  over;
  logic                  s_ready_c;
  logic                  accept;
  logic                  frame_end;

  // Bytes carried by the current input beat
  always_comb begin
    beat_bytes = '0;
    if (KEEP_ENABLE) begin
      for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
        beat_bytes = beat_bytes + LEN_WIDTH'(s_axis.tkeep[i]);
      end
    end else begin
      beat_bytes = LEN_WIDTH'(KEEP_WIDTH);
    end
  end

  // Saturating running length; the limit comes straight from max_len on a frame's first beat
  assign len_sum   = {1'b0, len_q} + {1'b0, beat_bytes};
  assign new_len   = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];
  assign lim       = in_frame_q ? lim_q : max_len;
  assign over      = (lim != '0) && (new_len > lim);
  assign s_ready_c = (state_q == ST_DROP) || !tvalid_q || m_axis.tready;
  assign accept    = s_axis.tvalid && s_ready_c;
  assign frame_end = accept && s_axis.tlast;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_PASS;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PASS: if (accept && over && !s_axis.tlast) state_d = ST_DROP;
      ST_DROP: if (frame_end) state_d = ST_PASS;
      default: state_d = ST_PASS;
    endcase
  end

  always_comb begin
    in_frame_d = in_frame_q;
    len_d      = len_q;
    lim_d      = lim_q;
    tdata_d    = tdata_q;
    tkeep_d    = tkeep_q;
    tlast_d    = tlast_q;
    tuser_d    = tuser_q;
    tvalid_d   = tvalid_q;
    good_d     = 1'b0;
    trunc_d    = 1'b0;

    if (accept) begin
      in_frame_d = !s_axis.tlast;
      len_d      = s_axis.tlast ? '0 : new_len;
      lim_d      = lim;
    end

    if (state_q == ST_PASS && accept) begin
      tdata_d  = s_axis.tdata;
      tkeep_d  = s_axis.tkeep;
      tlast_d  = s_axis.tlast || over;
      tuser_d  = over ? USER_BAD_FRAME_VALUE : s_axis.tuser;
      tvalid_d = 1'b1;
    end else if (m_axis.tready) begin
      tvalid_d = 1'b0;
    end

    // A frame ends truncated if it is already being dropped or crosses the limit on its last beat
    if (frame_end) begin
      trunc_d = (state_q == ST_DROP) || over;
      good_d  = !trunc_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_frame_q <= 1'b0;
      len_q      <= '0;
      lim_q      <= '0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tlast_q    <= 1'b0;
      tuser_q    <= '0;
      tvalid_q   <= 1'b0;
      good_q     <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      in_frame_q <= in_frame_d;
      len_q      <= len_d;
      lim_q      <= lim_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      tvalid_q   <= tvalid_d;
      good_q     <= good_d;
      trunc_q    <= trunc_d;
    end
  end

`ifdef AXIS_FRAME_LEN_STATUS_EN
  logic [LEN_WIDTH-1:0] frame_len_q, frame_len_d;
  logic                 flv_q, flv_d;

  always_comb begin
    frame_len_d = frame_len_q;
    flv_d       = frame_end;
    if (frame_end) frame_len_d = new_len;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_len_q <= '0;
      flv_q       <= 1'b0;
    end else begin
      frame_len_q <= frame_len_d;
      flv_q       <= flv_d;
    end
  end

  assign frame_len       = frame_len_q;
  assign frame_len_valid = flv_q;
`else
  assign frame_len       = '0;
  assign frame_len_valid = 1'b0;
`endif

  assign s_axis.tready     = s_ready_c;
  assign m_axis.tdata      = tdata_q;
  assign m_axis.tkeep      = tkeep_q;
  assign m_axis.tlast      = tlast_q;
  assign m_axis.tuser      = tuser_q;
  assign m_axis.tvalid     = tvalid_q;
  assign status_good_frame = good_q;
  assign status_truncated  = trunc_q;

endmodule

// File: tb/tb_axis_frame_len_limit.sv
// Bench for axis_frame_len_limit: directed frames plus randomized frames against a frame-level model.
module tb_axis_frame_len_limit;

  localparam int unsigned DW = 8;
  localparam int unsigned KW = 1;
  localparam int unsigned UW = 1;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] max_len;
  logic [LW-1:0] frame_len;
  logic          frame_len_valid;
  logic          status_good_frame;
  logic          status_truncated;

  axis_frame_len_limit_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) s_if ();
  axis_frame_len_limit_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) m_if ();

  axis_frame_len_limit #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .LEN_WIDTH(LW)) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis            (s_if),
    .m_axis            (m_if),
    .max_len           (max_len),
    .frame_len         (frame_len),
    .frame_len_valid   (frame_len_valid),
    .status_good_frame (status_good_frame),
    .status_truncated  (status_truncated)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic last; logic user; } beat_t;
  typedef struct { bit trunc; int len; } stat_t;

  beat_t exp_beats[$];
  stat_t exp_stat[$];
  int    tests_run    = 0;
  int    tests_failed = 0;
  bit    mon_en       = 1'b1;
  bit    rdy_rand     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output beats and status pulses are compared against the model's queues
  always @(negedge clk) begin
    beat_t b;
    stat_t s;
    if (mon_en && rst) begin
      if (m_if.tvalid && m_if.tready) begin
        if (exp_beats.size() == 0) chk("beat_unexpected", 32'd1, 32'd0);
        else begin
          b = exp_beats.pop_front();
          chk("out_data", 32'(m_if.tdata), 32'(b.data));
          chk("out_last", 32'(m_if.tlast), 32'(b.last));
          chk("out_user", 32'(m_if.tuser), 32'(b.user));
        end
      end
      if (status_good_frame || status_truncated || frame_len_valid) begin
        if (exp_stat.size() == 0) chk("status_unexpected", 32'd1, 32'd0);
        else begin
          s = exp_stat.pop_front();
          chk("status_good", 32'(status_good_frame), 32'(!s.trunc));
          chk("status_trunc", 32'(status_truncated), 32'(s.trunc));
`ifdef AXIS_FRAME_LEN_STATUS_EN
          chk("frame_len_valid", 32'(frame_len_valid), 32'd1);
          chk("frame_len", 32'(frame_len), 32'(s.len));
`else
          chk("frame_len_valid", 32'(frame_len_valid), 32'd0);
          chk("frame_len", 32'(frame_len), 32'd0);
`endif
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rdy_rand) begin
      #1;
      m_if.tready = ($urandom_range(0, 3) != 0);
    end
  end

  // Drives n_send beats of an n-beat frame; the model works from cumulative byte counts only
  task automatic send_frame(input int n, input int n_send, input logic [15:0] ml,
                            input int dmode, input bit use_model, input bit gaps);
    logic [7:0] d[];
    logic       u[];
    int         cum;
    int         cut;
    bit         over;
    bit         ok;
    d   = new[n];
    u   = new[n];
    cum = 0;
    cut = -1;
    for (int i = 0; i < n; i++) begin
      d[i] = (dmode == 0) ? 8'($urandom) : (dmode == 1) ? 8'(i + 1) : 8'((i + 1) * 17);
      u[i] = (dmode == 0) ? 1'($urandom) : 1'b0;
      cum  = (cum + 1 > 65535) ? 65535 : cum + 1;
      if (cut < 0) begin
        over = (ml != 0) && (cum > int'(ml));
        if (use_model) exp_beats.push_back('{d[i], (i == n - 1) || over, over ? 1'b1 : u[i]});
        if (over) cut = i;
      end
    end
    if (use_model) exp_stat.push_back('{cut >= 0, cum});

    for (int i = 0; i < n_send; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_if.tvalid = 1'b0;
        @(posedge clk); #1;
      end
      if (i == 0) max_len = ml;
      s_if.tvalid = 1'b1;
      s_if.tdata  = d[i];
      s_if.tuser  = u[i];
      s_if.tlast  = (i == n - 1);
      ok = 1'b0;
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk);
        if (cut >= 0 && i > cut) chk("drop_ready", 32'(s_if.tready), 32'd1);
        else chk("pass_ready", 32'(s_if.tready), 32'(!m_if.tvalid || m_if.tready));
        ok = s_if.tready;
        @(posedge clk); #1;
        if (ok) break;
      end
      if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
      max_len = 16'($urandom_range(0, 12));
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 1000; c++) begin
      if (exp_beats.size() == 0 && exp_stat.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_beats", 32'(exp_beats.size()), 32'd0);
    chk("drain_status", 32'(exp_stat.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_m_tvalid"}, 32'(m_if.tvalid), 32'd0);
    chk({tag, "_m_tdata"}, 32'(m_if.tdata), 32'd0);
    chk({tag, "_m_tlast"}, 32'(m_if.tlast), 32'd0);
    chk({tag, "_m_tuser"}, 32'(m_if.tuser), 32'd0);
    chk({tag, "_m_tkeep"}, 32'(m_if.tkeep), 32'd0);
    chk({tag, "_good"}, 32'(status_good_frame), 32'd0);
    chk({tag, "_trunc"}, 32'(status_truncated), 32'd0);
    chk({tag, "_flv"}, 32'(frame_len_valid), 32'd0);
    chk({tag, "_frame_len"}, 32'(frame_len), 32'd0);
  endtask

  initial begin
    rst         = 1'b0;
    max_len     = '0;
    s_if.tdata  = '0;
    s_if.tkeep  = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = '0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    send_frame(3, 3, 16'd4, 2, 1'b1, 1'b0);
    send_frame(4, 4, 16'd4, 2, 1'b1, 1'b0);
    send_frame(7, 7, 16'd4, 1, 1'b1, 1'b0);
    wait_drain();

    // Output stalled mid-frame: input must back-pressure while the output register is full
    fork
      send_frame(6, 6, 16'd0, 1, 1'b1, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1 m_if.tready = 1'b0;
        @(negedge clk);
        chk("stall_m_tvalid", 32'(m_if.tvalid), 32'd1);
        chk("stall_s_tready", 32'(s_if.tready), 32'd0);
        repeat (5) @(posedge clk);
        #1 m_if.tready = 1'b1;
      end
    join
    wait_drain();

    // Reset while dropping the tail of an over-long frame
    mon_en = 1'b0;
    send_frame(7, 6, 16'd4, 1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("mid_drop_reset");
    rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    send_frame(2, 2, 16'd4, 1, 1'b1, 1'b0);
    wait_drain();

    send_frame(300, 300, 16'd0, 0, 1'b1, 1'b0);
    wait_drain();

    rdy_rand = 1'b1;
    for (int f = 0; f < 60; f++) begin
      send_frame(int'($urandom_range(1, 20)), 0, 16'($urandom_range(0, 12)), 0, 1'b0, 1'b0);
    end
    for (int f = 0; f < 60; f++) begin
      int n;
      n = int'($urandom_range(1, 20));
      send_frame(n, n, 16'($urandom_range(0, 12)), 0, 1'b1, 1'b1);
    end
    @(posedge clk);
    rdy_rand = 1'b0;
    #1 m_if.tready = 1'b1;
    wait_drain();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
